// File: rtl/spi_tx_ctrl_if.sv
// spi_tx_ctrl_if: word handshake into the SPI transaction controller, shifter
// controls and SPI pins out. Optional D/C select (in_dc/lcd_dc) exists only
// when SPI_TX_DC_EN is defined.
interface spi_tx_ctrl_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [15:0] sh_data;
  logic        sh_load;
  logic        sh_shift_en;
  logic        sclk;
  logic        cs_n;
  logic        busy;
  logic        done;
`ifdef SPI_TX_DC_EN
  logic        in_dc;
  logic        lcd_dc;

  // Word source side.
  modport master (
    output in_valid, in_data, in_dc,
    input  in_ready, sh_data, sh_load, sh_shift_en, sclk, cs_n, busy, done, lcd_dc
  );

  // Controller side.
  modport slave (
    input  in_valid, in_data, in_dc,
    output in_ready, sh_data, sh_load, sh_shift_en, sclk, cs_n, busy, done, lcd_dc
  );
`else
  // Word source side.
  modport master (
    output in_valid, in_data,
    input  in_ready, sh_data, sh_load, sh_shift_en, sclk, cs_n, busy, done
  );

  // Controller side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, sh_data, sh_load, sh_shift_en, sclk, cs_n, busy, done
  );
`endif
endinterface

// File: rtl/spi_tx_ctrl.sv
// spi_tx_ctrl: sequences one 16-bit word into the SPI shifter (load, 16 shifts)
// and generates mode-0 SCLK and CS_N. Word latency accept->ready is
// 1 + 33*CLK_DIV + CS_GAP clocks; in_ready is low while a word is in flight.
// Optional macro SPI_TX_DC_EN adds in_dc/lcd_dc, latched on accept.
module spi_tx_ctrl #(
  parameter int CLK_DIV = 4,  // clocks per SCLK half-period, 1..255
  parameter int CS_GAP  = 2   // clocks cs_n stays high between words, 1..255
) (
  input logic          clk,
  input logic          rst,
  spi_tx_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_LOW, S_HIGH, S_TAIL, S_GAP
  } state_t;

  // Terminal counts for the shared phase counter. With CLK_DIV=1 the LOW
  // terminal wraps to 255, which is harmless because LOW is never entered.
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] LOW_LAST = 8'(CLK_DIV - 2);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [15:0] sh_data_q, sh_data_d;
  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        sh_load_q, sh_load_d;
  logic        sh_shift_en_q, sh_shift_en_d;
  logic        sclk_q, sclk_d;
  logic        cs_n_q, cs_n_d;
  logic        accept;

  // in_ready_q (not the state) gates acceptance, so nothing is taken in the
  // first cycle after reset release while in_ready is still low.
  assign accept = (state_q == S_IDLE) && bus.in_valid && in_ready_q;

  // Next state, phase counter, bit counter and data capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitcnt_d  = bitcnt_q;
    sh_data_d = sh_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sh_data_d = bus.in_data;
          bitcnt_d  = 5'd0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: state_d = S_SHIFT;
      S_SHIFT: begin
        cnt_d   = 8'd0;
        state_d = (CLK_DIV == 1) ? S_HIGH : S_LOW;
      end
      S_LOW: begin
        if (cnt_q == LOW_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HIGH: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d    = 8'd0;
          bitcnt_d = bitcnt_q + 5'd1;
          state_d  = (bitcnt_d == 5'd16) ? S_TAIL : S_SHIFT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_TAIL: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every pin is a flop that
  // settles at the rising edge, well ahead of the shifter's falling edge.
  always_comb begin
    in_ready_d    = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_q == S_GAP) && (state_d == S_IDLE);
    sh_load_d     = (state_d == S_LOAD);
    sh_shift_en_d = (state_d == S_SHIFT);
    sclk_d        = (state_d == S_HIGH);
    cs_n_d        = !(state_d inside {S_LOAD, S_SHIFT, S_LOW, S_HIGH, S_TAIL});
  end

  // State and output registers; reset abandons any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 8'd0;
      bitcnt_q      <= 5'd0;
      sh_data_q     <= 16'd0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      sh_load_q     <= 1'b0;
      sh_shift_en_q <= 1'b0;
      sclk_q        <= 1'b0;
      cs_n_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bitcnt_q      <= bitcnt_d;
      sh_data_q     <= sh_data_d;
      in_ready_q    <= in_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      sh_load_q     <= sh_load_d;
      sh_shift_en_q <= sh_shift_en_d;
      sclk_q        <= sclk_d;
      cs_n_q        <= cs_n_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.sh_data     = sh_data_q;
  assign bus.sh_load     = sh_load_q;
  assign bus.sh_shift_en = sh_shift_en_q;
  assign bus.sclk        = sclk_q;
  assign bus.cs_n        = cs_n_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

`ifdef SPI_TX_DC_EN
  logic lcd_dc_q, lcd_dc_d;

  // D/C select follows the word it was offered with and holds until the next accept.
  always_comb begin
    lcd_dc_d = lcd_dc_q;
    if (accept) lcd_dc_d = bus.in_dc;
  end

  // D/C register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lcd_dc_q <= 1'b0;
    else     lcd_dc_q <= lcd_dc_d;
  end

  assign bus.lcd_dc = lcd_dc_q;
`endif

endmodule

// File: tb/tb_spi_tx_ctrl.sv
// Bench for spi_tx_ctrl: lane 0 uses CLK_DIV=4/CS_GAP=2, lane 1 CLK_DIV=1/CS_GAP=1.
// Each lane has a cycle-offset model of the word timeline, a model of the
// external shifter, and a per-cycle compare; directed tests add literal checks.
module tb_spi_tx_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic        vld [2];
  logic [15:0] dat [2];
  logic        o_rdy [2], o_load [2], o_shen [2], o_sclk [2], o_csn [2], o_busy [2], o_done [2];
  logic [15:0] o_shd [2];
  logic [15:0] lrx [2];
  int          k_arr [2];
`ifdef SPI_TX_DC_EN
  logic        dc_in [2];
  logic        o_dc [2];
`endif

  task automatic chk(input int lane, input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL lane%0d %s: got 0x%0h, expected 0x%0h (t=%0t)", lane, nm, act, want, $time);
    end
  endtask

  // Offset k counts rising edges since the accept edge (k=0 is the LOAD cycle).
  function automatic bit in_win(input int k, input int d);
    return (k >= 1) && (k < 1 + 32 * d);
  endfunction

  function automatic int phase(input int k, input int d);
    return (k - 1) % (2 * d);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int D    = (g == 0) ? 4 : 1;
    localparam int G    = (g == 0) ? 2 : 1;
    localparam int LOWN = 1 + 33 * D;      // cs_n low length
    localparam int T    = 1 + 33 * D + G;  // accept edge to done edge

    spi_tx_ctrl_if bus ();
    assign bus.in_valid = vld[g];
    assign bus.in_data  = dat[g];
    assign o_rdy[g]  = bus.in_ready;
    assign o_load[g] = bus.sh_load;
    assign o_shen[g] = bus.sh_shift_en;
    assign o_sclk[g] = bus.sclk;
    assign o_csn[g]  = bus.cs_n;
    assign o_busy[g] = bus.busy;
    assign o_done[g] = bus.done;
    assign o_shd[g]  = bus.sh_data;
`ifdef SPI_TX_DC_EN
    assign bus.in_dc = dc_in[g];
    assign o_dc[g]   = bus.lcd_dc;
`endif

    spi_tx_ctrl #(.CLK_DIV(D), .CS_GAP(G)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    // k = -2: just reset (not ready); -1: idle and ready; >= 0: edges since accept.
    int          kk = -2;
    logic [15:0] word = 16'h0;
    logic        dcm = 1'b0;
    assign k_arr[g] = kk;

    // Word timeline model, advanced on every rising edge.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        kk   <= -2;
        word <= 16'h0;
        dcm  <= 1'b0;
      end else if (kk == -2) begin
        kk <= -1;
      end else if ((kk == -1 || kk >= T) && vld[g]) begin
        kk   <= 0;
        word <= dat[g];
`ifdef SPI_TX_DC_EN
        dcm  <= dc_in[g];
`endif
      end else if (kk >= 0 && kk <= T) begin
        kk <= kk + 1;
      end
    end

    logic [15:0] sr = 16'h0, rx = 16'h0, last_rx = 16'h0;
    logic        mosi = 1'b0, sclk_p = 1'b0, csn_p = 1'b1;
    int          rxn = 0;
    assign lrx[g] = last_rx;

    // Per-cycle compare plus the external shifter and the LCD's bit capture.
    always @(negedge clk) begin
      chk(g, "cs_n",        32'(bus.cs_n),        32'(!(kk >= 0 && kk < LOWN)));
      chk(g, "sclk",        32'(bus.sclk),        32'(in_win(kk, D) && phase(kk, D) >= D));
      chk(g, "sh_shift_en", 32'(bus.sh_shift_en), 32'(in_win(kk, D) && phase(kk, D) == 0));
      chk(g, "sh_load",     32'(bus.sh_load),     32'(kk == 0));
      chk(g, "busy",        32'(bus.busy),        32'(kk >= 0 && kk < T));
      chk(g, "done",        32'(bus.done),        32'(kk == T));
      chk(g, "in_ready",    32'(bus.in_ready),    32'(kk == -1 || kk >= T));
      chk(g, "sh_data",     32'(bus.sh_data),     32'(word));
`ifdef SPI_TX_DC_EN
      chk(g, "lcd_dc",      32'(bus.lcd_dc),      32'(dcm));
`endif
      if (rst) begin
        sr <= 16'h0; mosi <= 1'b0; rx <= 16'h0; rxn <= 0; sclk_p <= 1'b0; csn_p <= 1'b1;
      end else begin
        sclk_p <= bus.sclk;
        csn_p  <= bus.cs_n;
        if (bus.sclk && !sclk_p) begin
          rx  <= {rx[14:0], mosi};
          rxn <= rxn + 1;
        end
        if (bus.sh_load) begin
          sr   <= bus.sh_data;
          mosi <= 1'b0;
          rxn  <= 0;
        end else if (bus.sh_shift_en) begin
          mosi <= sr[15];
          sr   <= {sr[14:0], 1'b0};
        end
        if (bus.cs_n && !csn_p) begin
          chk(g, "bits per word", 32'(rxn), 32'd16);
          chk(g, "mosi word",     32'(rx),  32'(word));
          last_rx <= rx;
        end
      end
    end
  end

  // Waits (bounded) for the negedge right after an accept edge.
  task automatic wait_accept(input int l);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (k_arr[l] == 0) begin ok = 1'b1; break; end
    end
    chk(l, "accept seen", 32'(ok), 32'd1);
  endtask

  // Counts negedges after the accept until done is seen (bounded).
  task automatic wait_done(input int l, output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n++;
      if (o_done[l]) break;
    end
  endtask

  int n, hi, loads, shifts, r1, r2, rises;
  logic prev;

  initial begin
    for (int l = 0; l < 2; l++) begin
      vld[l] = 1'b0; dat[l] = 16'h0;
`ifdef SPI_TX_DC_EN
      dc_in[l] = 1'b0;
`endif
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk(0, "reset cs_n",     32'(o_csn[0]), 32'd1);
    chk(0, "reset sclk",     32'(o_sclk[0]), 32'd0);
    chk(0, "reset in_ready", 32'(o_rdy[0]), 32'd0);
    chk(0, "reset sh_data",  32'(o_shd[0]), 32'd0);
    #2 rst = 1'b0;
    #1 chk(0, "in_ready before first edge", 32'(o_rdy[0]), 32'd0);
    @(negedge clk);
    chk(0, "in_ready after first edge", 32'(o_rdy[0]), 32'd1);

    // Single word, defaults: 1010010111000011 on MOSI.
    vld[0] = 1'b1; dat[0] = 16'hA5C3;
    wait_accept(0);
    vld[0] = 1'b0; dat[0] = 16'h0;
    chk(0, "cs_n low after accept", 32'(o_csn[0]), 32'd0);
    wait_done(0, n);
    chk(0, "done latency A5C3", 32'(n), 32'd135);
    chk(0, "mosi A5C3", 32'(lrx[0]), 32'hA5C3);

    // Back-to-back with in_valid held: low window 133 + 2 GAP + 1 IDLE = 136,
    // so cs_n is seen high for 3 cycles between the two words.
    vld[0] = 1'b1; dat[0] = 16'hFFFF;
    wait_accept(0);
    dat[0] = 16'h0001;
    n = 0; hi = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n++;
      if (o_csn[0]) hi++;
      if (k_arr[0] == 0) break;
    end
    vld[0] = 1'b0;
    chk(0, "b2b accept spacing", 32'(n), 32'd136);
    chk(0, "b2b cs_n high cycles", 32'(hi), 32'd3);
    chk(0, "mosi FFFF", 32'(lrx[0]), 32'hFFFF);
    wait_done(0, n);
    chk(0, "mosi 0001", 32'(lrx[0]), 32'h0001);

    // Reset during data bit 7 of 0x1234 (9th bit on the wire, k=65..72).
    vld[0] = 1'b1; dat[0] = 16'h1234;
    wait_accept(0);
    vld[0] = 1'b0;
    repeat (66) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk(0, "mid-reset cs_n",        32'(o_csn[0]),  32'd1);
    chk(0, "mid-reset sclk",        32'(o_sclk[0]), 32'd0);
    chk(0, "mid-reset sh_load",     32'(o_load[0]), 32'd0);
    chk(0, "mid-reset sh_shift_en", 32'(o_shen[0]), 32'd0);
    chk(0, "mid-reset busy",        32'(o_busy[0]), 32'd0);
    chk(0, "mid-reset sh_data",     32'(o_shd[0]),  32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk(0, "in_ready at release", 32'(o_rdy[0]), 32'd0);
    @(negedge clk);
    chk(0, "in_ready one edge after release", 32'(o_rdy[0]), 32'd1);
    vld[0] = 1'b1; dat[0] = 16'h00FF;
    wait_accept(0);
    vld[0] = 1'b0;
    wait_done(0, n);
    chk(0, "done latency 00FF", 32'(n), 32'd135);
    chk(0, "mosi 00FF", 32'(lrx[0]), 32'h00FF);

    // in_valid / in_data toggling while busy must not disturb the word.
    vld[0] = 1'b1; dat[0] = 16'h5A0F;
    wait_accept(0);
    loads = o_load[0] ? 1 : 0; shifts = 0; n = 0;
    for (int i = 1; i < 400; i++) begin
      vld[0] = (i < 120) ? (i % 2 == 1) : 1'b0;
      dat[0] = 16'($urandom);
      @(negedge clk);
      n++;
      if (o_load[0]) loads++;
      if (o_shen[0]) shifts++;
      if (o_done[0]) break;
    end
    chk(0, "toggle sh_load count", 32'(loads), 32'd1);
    chk(0, "toggle shift count",   32'(shifts), 32'd16);
    chk(0, "toggle done latency",  32'(n), 32'd135);
    chk(0, "toggle mosi", 32'(lrx[0]), 32'h5A0F);
    dat[0] = 16'h0;

    // CLK_DIV=1, CS_GAP=1: no LOW phase, SCLK period 2, done after 35.
    vld[1] = 1'b1; dat[1] = 16'h8001;
    wait_accept(1);
    vld[1] = 1'b0;
    n = 0; r1 = -1; r2 = -1; rises = 0; prev = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n++;
      if (o_sclk[1] && !prev) begin
        rises++;
        if (r1 < 0) r1 = n; else if (r2 < 0) r2 = n;
      end
      prev = o_sclk[1];
      if (o_done[1]) break;
    end
    chk(1, "div1 first sclk rise", 32'(r1), 32'd2);
    chk(1, "div1 sclk period", 32'(r2 - r1), 32'd2);
    chk(1, "div1 sclk rises", 32'(rises), 32'd16);
    chk(1, "div1 done latency", 32'(n), 32'd35);
    chk(1, "mosi 8001", 32'(lrx[1]), 32'h8001);

`ifdef SPI_TX_DC_EN
    // D/C must hold through each word's whole cs_n-low window.
    vld[0] = 1'b1; dat[0] = 16'h002C; dc_in[0] = 1'b1;
    wait_accept(0);
    dc_in[0] = 1'b0; dat[0] = 16'h1234;
    hi = 0;
    for (int i = 0; i < 400; i++) begin
      if (!o_csn[0] && o_dc[0] !== 1'b1) hi++;
      @(negedge clk);
      if (k_arr[0] == 0) break;
    end
    vld[0] = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!o_csn[0] && o_dc[0] !== 1'b0) hi++;
      @(negedge clk);
      if (o_done[0]) break;
    end
    chk(0, "dc window errors", 32'(hi), 32'd0);
    chk(0, "mosi 1234 dc", 32'(lrx[0]), 32'h1234);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
